// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared defaults for the data RAM port arbiter
package mem_port_arbiter_pkg;
  localparam int DEF_CORES      = 4;
  localparam int DEF_LOG_CORES  = 2;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DBG_MAX    = 3;
  localparam int STREAK_W       = 4;
  typedef logic [STREAK_W-1:0] streak_t;
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// mem_port_arbiter_rr_pick: combinational round-robin one-hot picker
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int CORES     = DEF_CORES,
  parameter int LOG_CORES = DEF_LOG_CORES
) (
  input  logic [CORES-1:0]     req_i,
  input  logic [LOG_CORES-1:0] ptr_i,
  output logic [CORES-1:0]     gnt_o,
  output logic [LOG_CORES-1:0] idx_o,
  output logic                 any_o
);
  localparam logic [CORES-1:0] ONE = CORES'(1);
  logic [CORES-1:0]   mask;
  logic [2*CORES-1:0] dbl, first;
  // lower half keeps only requests at or above ptr, upper half wraps around
  always_comb begin
    mask  = ~((ONE << ptr_i) - ONE);
    dbl   = {req_i, req_i & mask};
    first = dbl & (-dbl);
    gnt_o = first[CORES-1:0] | first[2*CORES-1:CORES];
    idx_o = '0;
    for (int i = 0; i < CORES; i++) if (gnt_o[i]) idx_o = LOG_CORES'(i);
    any_o = |req_i;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port data RAM between the cores and a debug requester
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int CORES      = DEF_CORES,
  parameter int LOG_CORES  = DEF_LOG_CORES,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DBG_MAX    = DEF_DBG_MAX
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CORES-1:0]            core_req_i,
  input  logic [CORES-1:0]            core_we_i,
  input  logic [CORES*ADDR_WIDTH-1:0] core_addr_i,
  input  logic [CORES*DATA_WIDTH-1:0] core_wdata_i,
  output logic [CORES-1:0]            core_gnt_o,
  output logic [CORES-1:0]            core_rvalid_o,
  input  logic                        dbg_req_i,
  input  logic                        dbg_we_i,
  input  logic [ADDR_WIDTH-1:0]       dbg_addr_i,
  input  logic [DATA_WIDTH-1:0]       dbg_wdata_i,
  output logic                        dbg_gnt_o,
  output logic                        dbg_rvalid_o,
  output logic [DATA_WIDTH-1:0]       rdata_o,
  output logic                        mem_en_o,
  output logic                        mem_we_o,
  output logic [ADDR_WIDTH-1:0]       mem_addr_o,
  output logic [DATA_WIDTH-1:0]       mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]       mem_rdata_i
);
  logic [LOG_CORES-1:0] rr_ptr_q, rr_ptr_d, pick_idx;
  streak_t              dbg_streak_q, dbg_streak_d;
  logic [CORES-1:0]     core_rvalid_q, core_rvalid_d, pick_gnt;
  logic                 dbg_rvalid_q, dbg_rvalid_d, pick_any, core_win;
  mem_port_arbiter_rr_pick #(.CORES(CORES), .LOG_CORES(LOG_CORES)) u_pick (
    .req_i(core_req_i),
    .ptr_i(rr_ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );
  // debug wins unless it has used up its streak while a core is waiting
  always_comb begin
    dbg_gnt_o     = dbg_req_i && !(dbg_streak_q == streak_t'(DBG_MAX) && pick_any);
    core_win      = !dbg_gnt_o && pick_any;
    core_gnt_o    = core_win ? pick_gnt : '0;
    mem_en_o      = dbg_gnt_o || core_win;
    mem_we_o      = dbg_gnt_o ? dbg_we_i : core_win && core_we_i[pick_idx];
    mem_addr_o    = dbg_gnt_o ? dbg_addr_i : core_win ? core_addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    mem_wdata_o   = dbg_gnt_o ? dbg_wdata_i : core_win ? core_wdata_i[pick_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    rr_ptr_d      = core_win ? pick_idx + LOG_CORES'(1) : rr_ptr_q;
    dbg_streak_d  = !dbg_gnt_o ? '0 :
                    (pick_any && dbg_streak_q != streak_t'(DBG_MAX)) ? dbg_streak_q + streak_t'(1) : dbg_streak_q;
    core_rvalid_d = core_gnt_o & ~core_we_i;
    dbg_rvalid_d  = dbg_gnt_o && !dbg_we_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      dbg_streak_q  <= '0;
      core_rvalid_q <= '0;
      dbg_rvalid_q  <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      dbg_streak_q  <= dbg_streak_d;
      core_rvalid_q <= core_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
    end
  end
  assign core_rvalid_o = core_rvalid_q;
  assign dbg_rvalid_o  = dbg_rvalid_q;
  assign rdata_o       = mem_rdata_i;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the data RAM port arbiter with a behavioural RAM
module tb_mem_port_arbiter;
  localparam int C = 4, AW = 5, DW = 16;
  logic clk, rst_n;
  logic [C-1:0] core_req, core_we, core_gnt, core_rvalid;
  logic [C*AW-1:0] core_addr;
  logic [C*DW-1:0] core_wdata;
  logic dbg_req, dbg_we, dbg_gnt, dbg_rvalid, mem_en, mem_we;
  logic [AW-1:0] dbg_addr, mem_addr;
  logic [DW-1:0] dbg_wdata, rdata, mem_wdata, mem_rdata;
  logic [DW-1:0] ram [32];
  logic pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  typedef struct packed {logic [4:0] who; logic [DW-1:0] data;} exp_t;
  exp_t q[$];
  int n_tests = 0, n_fail = 0;

  mem_port_arbiter #(.CORES(C), .LOG_CORES(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DBG_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .rdata_o(rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic clear_inputs();
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic set_core(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_req[i] = 1'b1; core_we[i] = we; core_addr[i*AW +: AW] = a; core_wdata[i*DW +: DW] = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    q.delete();
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL %s: got %0d expected %0d", name, got, exp); end
  endtask

  // one cycle: check the grant now, push an expected read, then check the registered return
  task automatic step(input logic [4:0] eg, input logic rd, input logic [DW-1:0] ed);
    exp_t e;
    logic [4:0] rv;
    #1;
    n_tests++;
    if ({dbg_gnt, core_gnt} !== eg) begin n_fail++; $display("FAIL grant: got %b expected %b", {dbg_gnt, core_gnt}, eg); end
    n_tests++;
    if (mem_en !== (eg != 5'b0)) begin n_fail++; $display("FAIL mem_en: got %b expected %b", mem_en, eg != 5'b0); end
    if (rd) q.push_back({eg, ed});
    @(posedge clk); #1;
    rv = {dbg_rvalid, core_rvalid};
    e = (q.size() != 0) ? q.pop_front() : '0;
    n_tests++;
    if (rv !== e.who) begin n_fail++; $display("FAIL rvalid: got %b expected %b", rv, e.who); end
    if (e.who != 5'b0) begin
      n_tests++;
      if (rdata !== e.data) begin n_fail++; $display("FAIL rdata: got %h expected %h", rdata, e.data); end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    check_int("reset_gnt", {dbg_gnt, core_gnt}, 0);
    check_int("reset_rvalid", {dbg_rvalid, core_rvalid}, 0);
    check_int("reset_mem_en", mem_en, 0);
    check_int("reset_mem_we", mem_we, 0);
    check_int("reset_rr_ptr", dut.rr_ptr_q, 0);
    check_int("reset_streak", dut.dbg_streak_q, 0);
    set_core(2, 0, 9, 0);
    #1;
    check_int("reset_comb_gnt", core_gnt, 4'b0100);
    check_int("reset_comb_addr", mem_addr, 9);
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
  endtask

  task automatic test_single_read();
    apply_reset();
    set_core(1, 0, 5, 0);
    #1;
    check_int("single_addr", mem_addr, 5);
    check_int("single_we", mem_we, 0);
    step(5'b00010, 1, 16'h1234);
    clear_inputs();
    check_int("single_rr_ptr", dut.rr_ptr_q, 2);
    step(5'b0, 0, 0);
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < C; i++) set_core(i, 0, AW'(8 + i), 0);
    for (int k = 0; k < 5; k++) step(5'(1 << (k % C)), 1, DW'(16'hA000 + k % C));
    clear_inputs();
    step(5'b0, 0, 0);
  endtask

  task automatic test_dbg_priority();
    apply_reset();
    dbg_req = 1; dbg_we = 0; dbg_addr = 3;
    set_core(2, 0, 7, 0);
    for (int k = 0; k < 3; k++) step(5'b10000, 1, 16'h0D0D);
    check_int("streak_max", dut.dbg_streak_q, 3);
    step(5'b00100, 1, 16'h7777);
    core_req = '0;
    check_int("streak_cleared", dut.dbg_streak_q, 0);
    step(5'b10000, 1, 16'h0D0D);
    check_int("streak_no_wait", dut.dbg_streak_q, 0);
    dbg_req = 0;
    step(5'b0, 0, 0);
  endtask

  task automatic test_dbg_alone();
    apply_reset();
    dbg_req = 1; dbg_we = 1; dbg_addr = 20;
    for (int k = 0; k < 10; k++) begin
      dbg_wdata = DW'(k);
      step(5'b10000, 0, 0);
      check_int("alone_streak", dut.dbg_streak_q, 0);
    end
    dbg_req = 0;
    step(5'b0, 0, 0);
  endtask

  task automatic test_write_then_read();
    apply_reset();
    dbg_req = 1; dbg_we = 1; dbg_addr = 31; dbg_wdata = 16'hBEEF;
    #1;
    check_int("wr_mem_we", mem_we, 1);
    check_int("wr_mem_addr", mem_addr, 31);
    check_int("wr_mem_wdata", mem_wdata, 16'hBEEF);
    step(5'b10000, 0, 0);
    clear_inputs();
    set_core(3, 0, 31, 0);
    #1;
    check_int("rd_mem_we", mem_we, 0);
    step(5'b01000, 1, 16'hBEEF);
    clear_inputs();
    step(5'b0, 0, 0);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    dbg_req = 1; dbg_we = 0; dbg_addr = 3;
    set_core(0, 0, 8, 0);
    step(5'b10000, 1, 16'h0D0D);
    check_int("mid_streak_pre", dut.dbg_streak_q, 1);
    dbg_req = 0;
    #1;
    check_int("mid_core_gnt", core_gnt, 4'b0001);
    @(negedge clk);
    rst_n = 0;
    #1;
    check_int("mid_streak_async", dut.dbg_streak_q, 0);
    clear_inputs();
    @(posedge clk); #1;
    check_int("mid_rvalid", {dbg_rvalid, core_rvalid}, 0);
    check_int("mid_rr_ptr", dut.rr_ptr_q, 0);
    @(negedge clk);
    rst_n = 1;
    check_int("mid_queue", q.size(), 0);
    step(5'b0, 0, 0);
  endtask

  initial begin
    pre_en = 0; pre_addr = '0; pre_data = '0;
    test_reset();
    preload(5, 16'h1234);
    for (int i = 0; i < C; i++) preload(AW'(8 + i), DW'(16'hA000 + i));
    preload(3, 16'h0D0D);
    preload(7, 16'h7777);
    test_single_read();
    test_round_robin();
    test_dbg_priority();
    test_dbg_alone();
    test_write_then_read();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
